// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//
// Handshaked, WIDTH-generic ALU. It accepts one operation at a time over a
// valid/ready request channel and returns a registered result and zero flag
// over a valid/ready response channel. Multiplication is performed by an
// iterative shift-add engine, one multiplier bit per cycle.
//
// Ports:
//   clk        in   clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operation request
//   in_ready   out  request can be accepted (high only in IDLE)
//   op         in   3-bit opcode: 001 add, 010 and, 011 or, 100 mul,
//                   101 sub, 110 unsigned set-less-than; others give 0
//   a, b       in   WIDTH-bit operands
//   out_valid  out  result/zero valid (DONE state)
//   out_ready  in   consumer accepts the result
//   result     out  WIDTH-bit registered result
//   zero       out  registered (result == 0) flag
//   busy       out  multiply in progress (MUL state)
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_sum;

  // Single-cycle result for every non-multiply opcode. The mul code falls
  // into the default arm here; it never reaches this path from IDLE.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add the (already shifted) multiplicand when the
  // current multiplier LSB is set. Sum wraps, giving the low WIDTH bits.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            state_d  = S_DONE;
          end
        end
      end

      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Counter at 1 means this is the last bit: publish the final sum
        // directly rather than waiting a cycle for acc_q to catch up.
        if (cnt_q == CW'(1)) begin
          result_d = acc_sum;
          zero_d   = (acc_sum == '0);
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  int n_checks;
  int n_fail;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for exactly one accept edge, then wait (bounded) for
  // out_valid. lat counts cycles from the accept cycle (accept cycle = 0).
  // busy_cnt counts cycles in which busy was seen high.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, output int lat, output int busy_cnt);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'b000; a = '0; b = '0;  // later changes must not matter
    lat = 1;
    busy_cnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== '0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b result=%h zero=%b, required 1 0 0 0 0",
               in_ready, out_valid, busy, result, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: in_ready=%b out_valid=%b busy=%b result=%h zero=%b", in_ready, out_valid, busy, result, zero);
  endtask

  task automatic test_basic_ops();
    logic [2:0]   ops [4] = '{3'b001, 3'b010, 3'b011, 3'b101};
    logic [W-1:0] as  [4] = '{32'hFFFF_FFFF, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0};
    logic [W-1:0] bs  [4] = '{32'h1, 32'h0000_FF00, 32'h0000_0F0F, 32'h1};
    logic [W-1:0] exp [4] = '{32'h0, 32'h0000_F000, 32'h0000_FFFF, 32'hFFFF_FFFF};
    logic         expz[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], lat, bc);
      n_checks++;
      if (result !== exp[i] || zero !== expz[i]) begin
        n_fail++;
        $display("FAIL basic_op%0d: result=%h zero=%b, required %h %b", i, result, zero, exp[i], expz[i]);
      end
      n_checks++;
      if (lat !== 1) begin
        n_fail++;
        $display("FAIL basic_lat%0d: latency=%0d, required 1", i, lat);
      end
      $display("basic op=%b a=%h b=%h -> result=%h zero=%b lat=%0d", ops[i], as[i], bs[i], result, zero, lat);
      consume();
    end
  endtask

  task automatic test_slt_unused();
    logic [2:0]   ops [4] = '{3'b110, 3'b110, 3'b000, 3'b111};
    logic [W-1:0] as  [4] = '{32'd3, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [W-1:0] bs  [4] = '{32'd5, 32'h1, 32'h1111_1111, 32'hFFFF_FFFF};
    logic [W-1:0] exp [4] = '{32'd1, 32'd0, 32'd0, 32'd0};
    logic         expz[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], lat, bc);
      n_checks++;
      if (result !== exp[i] || zero !== expz[i] || lat !== 1) begin
        n_fail++;
        $display("FAIL slt_unused%0d: result=%h zero=%b lat=%0d, required %h %b 1",
                 i, result, zero, lat, exp[i], expz[i]);
      end
      $display("slt/unused op=%b a=%h b=%h -> result=%h zero=%b", ops[i], as[i], bs[i], result, zero);
      consume();
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] as  [2] = '{32'd12345, 32'h0001_0000};
    logic [W-1:0] bs  [2] = '{32'd6789,  32'h0001_0000};
    logic [W-1:0] exp [2] = '{32'd83810205, 32'd0};
    logic         expz[2] = '{1'b0, 1'b1};
    int lat, bc;
    for (int i = 0; i < 2; i++) begin
      issue(3'b100, as[i], bs[i], lat, bc);
      n_checks++;
      if (result !== exp[i] || zero !== expz[i]) begin
        n_fail++;
        $display("FAIL mul%0d: result=%0d zero=%b, required %0d %b", i, result, zero, exp[i], expz[i]);
      end
      n_checks++;
      if (lat !== W + 1) begin
        n_fail++;
        $display("FAIL mul_lat%0d: latency=%0d, required %0d", i, lat, W + 1);
      end
      n_checks++;
      if (bc !== W || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_busy%0d: busy cycles=%0d busy_now=%b, required %0d 0", i, bc, busy, W);
      end
      $display("mul a=%0d b=%0d -> result=%0d zero=%b lat=%0d busy_cycles=%0d", as[i], bs[i], result, zero, lat, bc);
      consume();
    end
  endtask

  task automatic test_back_pressure();
    int lat, bc;
    issue(3'b001, 32'd5, 32'd7, lat, bc);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        op = 3'b001; a = 32'd100; b = 32'd100; in_valid = 1'b1;
      end
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd12 || zero !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: out_valid=%b in_ready=%b result=%0d zero=%b, required 1 0 12 0",
                 c, out_valid, in_ready, result, zero);
      end
      $display("backpressure cycle %0d: out_valid=%b in_ready=%b result=%0d", c, out_valid, in_ready, result);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release_same: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd12) begin
      n_fail++;
      $display("FAIL backpressure_release_next: in_ready=%b out_valid=%b result=%0d, required 1 0 12",
               in_ready, out_valid, result);
    end
    $display("backpressure release: in_ready=%b out_valid=%b result=%0d", in_ready, out_valid, result);
  endtask

  task automatic test_reset_mid_op();
    int lat, bc;
    // Accept a multiply (accept cycle counts as cycle 1), run to cycle 10.
    @(negedge clk);
    op = 3'b100; a = 32'd7; b = 32'd6; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_busy: busy=%b, required 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== '0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: in_ready=%b out_valid=%b busy=%b result=%h zero=%b, required 1 0 0 0 0",
               in_ready, out_valid, busy, result, zero);
    end
    $display("midop reset: in_ready=%b out_valid=%b busy=%b result=%h", in_ready, out_valid, busy, result);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b001, 32'd1, 32'd1, lat, bc);
    n_checks++;
    if (result !== 32'd2 || zero !== 1'b0 || lat !== 1) begin
      n_fail++;
      $display("FAIL midop_after: result=%0d zero=%b lat=%0d, required 2 0 1", result, zero, lat);
    end
    $display("after midop reset add 1+1 -> result=%0d lat=%0d", result, lat);
    consume();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 3'b000;
    a = '0;
    b = '0;
    test_reset();
    test_basic_ops();
    test_slt_unused();
    test_mul();
    test_back_pressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
